// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive stimulus/capture stage for a 3-input
// combinational block. A start edge runs {a,b,c} through 000..111. Each vector
// is held for SETTLE_CYCLES cycles (0 is treated as 1). y_in is then sampled
// for one cycle and checked against EXPECTED.
//
// Optional feature macro: TT_SWEEP_DEBOUNCE_EN. When it is defined, start is
// debounced over DEBOUNCE_CYCLES consecutive equal samples before the edge
// detector sees it.
//
// Handshake: there is no valid/ready pair. start is a level whose rising
// edge, seen in IDLE or DONE, launches a sweep. done stays high until the next
// accepted start. result/fail_cnt/fail_idx are valid whenever done is high.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter logic [7:0]  EXPECTED        = 8'hFF,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] result,
  output logic [3:0] fail_cnt,
  output logic [2:0] fail_idx,
  output logic [1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned SETTLE_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_EFF - 1);

  // The debounce counter is 16 bits wide, so larger debounce lengths cannot be honoured.
  if (DEBOUNCE_CYCLES > 65535) begin : g_deb_range_err
    $error("DEBOUNCE_CYCLES exceeds the 16-bit debounce counter");
  end

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] settle_q, settle_d;
  logic [7:0]  result_q, result_d;
  logic [3:0]  fail_cnt_q, fail_cnt_d;
  logic [2:0]  fail_idx_q, fail_idx_d;

  logic start_q;      // raw start, registered once
  logic start_lvl;    // level seen by the edge detector
  logic start_prev_q; // previous start_lvl
  logic start_rise;

  // Register the raw start input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start;
  end

`ifdef TT_SWEEP_DEBOUNCE_EN
  logic        cand_q, cand_d;
  logic        deb_q, deb_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;

  // Debounce: count consecutive samples equal to the candidate level.
  // The sample that changes the candidate counts as the first one.
  always_comb begin
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    deb_d     = deb_q;
    if (start_q != cand_q) begin
      cand_d    = start_q;
      deb_cnt_d = 16'd1;
    end else if (deb_cnt_q != 16'hFFFF) begin
      deb_cnt_d = deb_cnt_q + 16'd1;
    end
    if (32'(deb_cnt_d) >= DEBOUNCE_CYCLES) deb_d = cand_d;
  end

  // Debouncer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q    <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= 16'd0;
    end else begin
      cand_q    <= cand_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign start_lvl = deb_q;
`else
  assign start_lvl = start_q;
`endif

  // Previous level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_prev_q <= 1'b0;
    else        start_prev_q <= start_lvl;
  end

  assign start_rise = start_lvl & ~start_prev_q;

  // Next-state logic: sweep sequencing, capture and mismatch tracking.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    result_d   = result_q;
    fail_cnt_d = fail_cnt_q;
    fail_idx_d = fail_idx_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_rise) begin
          state_d    = ST_DRIVE;
          idx_d      = 3'd0;
          settle_d   = 16'd0;
          result_d   = 8'h00;
          fail_cnt_d = 4'd0;
          fail_idx_d = 3'd0;
        end
      end
      ST_DRIVE: begin
        settle_d = settle_q + 16'd1;
        if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        result_d[idx_q] = y_in;
        if (y_in != EXPECTED[idx_q]) begin
          fail_cnt_d = fail_cnt_q + 4'd1;
          if (fail_cnt_q == 4'd0) fail_idx_d = idx_q;
        end
        if (idx_q == 3'd7) begin
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + 3'd1;
          settle_d = 16'd0;
          state_d  = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset returns everything to IDLE/zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      settle_q   <= 16'd0;
      result_q   <= 8'h00;
      fail_cnt_q <= 4'd0;
      fail_idx_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      result_q   <= result_d;
      fail_cnt_q <= fail_cnt_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // The index register drives the stimulus directly. In DONE it rests at 7, so {a,b,c}=111 there.
  assign {a, b, c}   = idx_q;
  assign busy        = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done        = (state_q == ST_DONE);
  assign pass        = done && (fail_cnt_q == 4'd0);
  assign result      = result_q;
  assign fail_cnt    = fail_cnt_q;
  assign fail_idx    = fail_idx_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper (default parameters). Works in both builds;
// with TT_SWEEP_DEBOUNCE_EN the expected start latency grows by 4 cycles.
module tb_truth_table_sweeper;

`ifdef TT_SWEEP_DEBOUNCE_EN
  localparam int EXTRA = 4;
  localparam int PULSE = 6;
`else
  localparam int EXTRA = 0;
  localparam int PULSE = 1;
`endif
  localparam logic [7:0] EXP_TT = 8'hFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       y_in;
  logic       a, b, c, busy, done, pass;
  logic [7:0] result;
  logic [3:0] fail_cnt;
  logic [2:0] fail_idx;
  logic [1:0] state_dbg;
  int         mode = 0;

  truth_table_sweeper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .result(result), .fail_cnt(fail_cnt), .fail_idx(fail_idx),
    .state_dbg_o(state_dbg)
  );

  // Behaviour of the block under test for each mode: 0 -> 1, 1 -> a&b&c, 2 -> ~(a&b&c).
  function automatic logic yfun(input int m, input logic [2:0] v);
    case (m)
      0:       return 1'b1;
      1:       return &v;
      default: return ~(&v);
    endcase
  endfunction

  always_comb y_in = yfun(mode, {a, b, c});

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {result, fail_cnt, fail_idx, pass} for one sweep in a given mode.
  function automatic logic [15:0] model(input int m);
    logic [7:0] r;
    logic [3:0] fc;
    logic [2:0] fi;
    logic       yv;
    r = 8'h00; fc = 4'd0; fi = 3'd0;
    for (int i = 0; i < 8; i++) begin
      yv = yfun(m, 3'(i));
      r[i] = yv;
      if (yv != EXP_TT[i]) begin
        if (fc == 4'd0) fi = 3'(i);
        fc = fc + 4'd1;
      end
    end
    return {r, fc, fi, (fc == 4'd0)};
  endfunction

  task automatic compare_result(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"},   32'(result),   32'(e[15:8]));
      check({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(e[7:4]));
      check({tag, "_fail_idx"}, 32'(fail_idx), 32'(e[3:1]));
      check({tag, "_pass"},     32'(pass),     32'(e[0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Launch a sweep and follow it to done. start is held for PULSE edges.
  // An optional one-cycle extra start pulse goes in at edge inj_at, while busy.
  task automatic sweep(input string tag, input int m, input int inj_at, input bit chk_abc);
    int n;
    int off;
    mode = m;
    exp_q.push_back(model(m));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;           // edge k: start registered
    n = 0;
    if (PULSE == 1) start = 1'b0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      off = n - EXTRA;
      if (n == PULSE - 1) start = 1'b0;
      if (inj_at > 0 && n == inj_at)     start = 1'b1;
      if (inj_at > 0 && n == inj_at + 1) start = 1'b0;
      if (off == 1) begin
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_pass_clr"}, 32'(pass), 32'd0);
      end
      if (chk_abc && off >= 1 && off <= 24) begin
        check({tag, "_abc"},  32'({a, b, c}), 32'((off - 1) / 3));
        check({tag, "_busy"}, 32'(busy), 32'd1);
      end
      if (done && off > 1) break;
    end
    check({tag, "_done_latency"}, 32'(n), 32'(25 + EXTRA));
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_abc_done"}, 32'({a, b, c}), 32'd7);
    compare_result(tag);
  endtask

  // Reset outputs must all be zero.
  task automatic check_zero(input string tag);
    check({tag, "_abc"},      32'({a, b, c}), 32'd0);
    check({tag, "_busy"},     32'(busy),      32'd0);
    check({tag, "_done"},     32'(done),      32'd0);
    check({tag, "_pass"},     32'(pass),      32'd0);
    check({tag, "_result"},   32'(result),    32'd0);
    check({tag, "_fail_cnt"}, 32'(fail_cnt),  32'd0);
    check({tag, "_fail_idx"}, 32'(fail_idx),  32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held for 3 cycles, then released in IDLE with no start.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("rst_hold");
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_zero("rst_idle");

    // All-ones sweep with stepping and timing checks.
    sweep("ones", 0, 0, 1'b1);
    // Mismatch sweeps, each started from DONE.
    sweep("and3", 1, 0, 1'b0);
    sweep("nand3", 2, 0, 1'b0);

    // Start pulsed while busy on vector 3: no restart, done still at k+25.
    sweep("busy_start", 0, EXTRA + 10, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("busy_start_hold_done", 32'(done), 32'd1);
    check("busy_start_hold_busy", 32'(busy), 32'd0);

    // Reset in the middle of vector 4.
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    if (PULSE == 1) start = 1'b0;
    for (int i = 1; i <= EXTRA + 14; i++) begin
      @(posedge clk); #1;
      if (i == PULSE - 1) start = 1'b0;
    end
    check("mid_vec4_abc", 32'({a, b, c}), 32'd4);
    check("mid_vec4_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_zero("mid_rst_no_resume");
    sweep("after_rst", 0, 0, 1'b1);

`ifdef TT_SWEEP_DEBOUNCE_EN
    // A 2-cycle glitch must not start a sweep.
    @(negedge clk) start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("glitch_no_busy", 32'(busy), 32'd0);
    end
    check("glitch_done_kept", 32'(done), 32'd1);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
